acc_requant_pack: RTL

//  Output stage directly downstream of the pipelined accumulator in the cnna datapath.

---
 rtl/acc_requant_pack.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/acc_requant_pack.sv
// Requantise accumulator sums (bias, round, shift, saturate, ReLU), pack C_PACK elements per
// word and queue words in a first-word-fall-through FIFO toward the obuf writer.
module acc_requant_pack #(
  parameter int unsigned C_IN    = 13,
  parameter int unsigned C_OW    = 8,
  parameter int unsigned C_PACK  = 4,
  parameter int unsigned C_SHW   = 5,
  parameter int unsigned C_DEPTH = 8,
  parameter int unsigned C_AW    = 3
) (
  input  logic                   I_clk,
  input  logic                   I_rst,
  input  logic [C_IN-1:0]        I_result,
  input  logic                   I_result_rdy,
  input  logic                   I_flush,
  input  logic [C_IN-1:0]        I_bias,
  input  logic [C_SHW-1:0]       I_shift,
  input  logic                   I_relu_en,
  output logic                   O_afull,
  output logic                   O_overflow,
  output logic [C_PACK*C_OW-1:0] O_dout,
  output logic                   O_dout_vld,
  input  logic                   I_dout_rdy
);

  localparam int unsigned S2W  = C_IN + 2;
  localparam int unsigned CNTW = (C_PACK > 1) ? $clog2(C_PACK) : 1;
  // Any shift of at least C_IN+1 rounds every possible sum to zero.
  localparam logic [C_SHW-1:0]        SH_ZERO = C_SHW'(C_IN + 1);
  localparam logic signed [S2W-1:0]   SAT_HI  = S2W'((1 << (C_OW - 1)) - 1);
  localparam logic signed [S2W-1:0]   SAT_LO  = ~SAT_HI;
  localparam logic [C_AW:0]           DEPTH_C = (C_AW + 1)'(C_DEPTH);
  localparam logic [C_AW:0]           AFULL_C = (C_AW + 1)'(C_DEPTH - 4);
  localparam logic [CNTW-1:0]         LAST_C  = CNTW'(C_PACK - 1);

  // Pipeline registers: input capture, bias add, round/shift, saturate
  logic                    in_vld_q, in_flush_q;
  logic [C_IN-1:0]         in_res_q;
  logic                    s1_vld_q, s1_flush_q;
  logic signed [C_IN:0]    s1_q;
  logic                    s2_vld_q, s2_flush_q;
  logic signed [S2W-1:0]   s2_q, s2_d;
  logic                    s3_vld_q, s3_flush_q;
  logic [C_OW-1:0]         s3_q, s3_d;

  logic signed [S2W-1:0]   s1_ext, rnd, sum;
  logic [C_SHW-1:0]        sh_m1;

  always_comb begin
    s1_ext = {s1_q[C_IN], s1_q};
    sh_m1  = I_shift - C_SHW'(1);
    rnd    = S2W'(1) << sh_m1;
    sum    = s1_ext + rnd;
    s2_d   = sum >>> I_shift;
    if (I_shift == '0) begin
      s2_d = s1_ext;
    end else if (I_shift >= SH_ZERO) begin
      s2_d = '0;
    end
  end

  always_comb begin
    s3_d = s2_q[C_OW-1:0];
    if (s2_q > SAT_HI) begin
      s3_d = SAT_HI[C_OW-1:0];
    end else if (s2_q < SAT_LO) begin
      s3_d = SAT_LO[C_OW-1:0];
    end
    if (I_relu_en && s3_d[C_OW-1]) begin
      s3_d = '0;
    end
  end

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      in_vld_q   <= 1'b0;
      in_flush_q <= 1'b0;
      in_res_q   <= '0;
      s1_vld_q   <= 1'b0;
      s1_flush_q <= 1'b0;
      s1_q       <= '0;
      s2_vld_q   <= 1'b0;
      s2_flush_q <= 1'b0;
      s2_q       <= '0;
      s3_vld_q   <= 1'b0;
      s3_flush_q <= 1'b0;
      s3_q       <= '0;
    end else begin
      in_vld_q   <= I_result_rdy;
      in_flush_q <= I_flush;
      in_res_q   <= I_result;
      s1_vld_q   <= in_vld_q;
      s1_flush_q <= in_flush_q;
      s1_q       <= {in_res_q[C_IN-1], in_res_q} + {I_bias[C_IN-1], I_bias};
      s2_vld_q   <= s1_vld_q;
      s2_flush_q <= s1_flush_q;
      s2_q       <= s2_d;
      s3_vld_q   <= s2_vld_q;
      s3_flush_q <= s2_flush_q;
      s3_q       <= s3_d;
    end
  end

  // Lane packer; lanes are cleared on every push so unused lanes of a flushed word read 0
  logic [C_PACK-1:0][C_OW-1:0] lanes_q, lanes_d, push_word;
  logic [CNTW-1:0]             cnt_q, cnt_d;
  logic                        push;

  always_comb begin
    lanes_d   = lanes_q;
    cnt_d     = cnt_q;
    push      = 1'b0;
    push_word = lanes_q;
    if (s3_vld_q) begin
      push_word[cnt_q] = s3_q;
      if (s3_flush_q || cnt_q == LAST_C) begin
        push    = 1'b1;
        lanes_d = '0;
        cnt_d   = '0;
      end else begin
        lanes_d = push_word;
        cnt_d   = cnt_q + CNTW'(1);
      end
    end else if (s3_flush_q && cnt_q != '0) begin
      push    = 1'b1;
      lanes_d = '0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      lanes_q <= '0;
      cnt_q   <= '0;
    end else begin
      lanes_q <= lanes_d;
      cnt_q   <= cnt_d;
    end
  end

  // Output FIFO
  logic [C_PACK-1:0][C_OW-1:0] mem_q [C_DEPTH];
  logic [C_AW-1:0]             wr_ptr_q, rd_ptr_q;
  logic [C_AW:0]               count_q, count_d;
  logic                        full, pop, wr_en, afull_q, ovf_q;

  assign full       = (count_q == DEPTH_C);
  assign O_dout_vld = (count_q != '0);
  assign pop        = O_dout_vld && I_dout_rdy;
  // A pop frees the slot in the same cycle, so a push into a full FIFO is kept when popping.
  assign wr_en      = push && (!full || pop);
  assign O_dout     = O_dout_vld ? mem_q[rd_ptr_q] : '0;
  assign O_afull    = afull_q;
  assign O_overflow = ovf_q;

  always_comb begin
    count_d = count_q;
    if (wr_en && !pop) begin
      count_d = count_q + (C_AW + 1)'(1);
    end else if (!wr_en && pop) begin
      count_d = count_q - (C_AW + 1)'(1);
    end
  end

  always_ff @(posedge I_clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= push_word;
    end
  end

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      afull_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + C_AW'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + C_AW'(1);
      count_q <= count_d;
      afull_q <= (count_d >= AFULL_C);
      ovf_q   <= ovf_q | (push && full && !pop);
    end
  end

endmodule
